// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the data-memory access controller.
//   basic_data_t      : 32-bit data word moved between pipeline and memory
//   dmem_ctrl_state_e : controller FSM states
//   is_aligned()      : decides whether a load/store may be issued as-is
package dmem_access_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef logic [DATA_W-1:0] basic_data_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } dmem_ctrl_state_e;

  // Loads are always full words; stores are checked against their byte-enable shape.
  function automatic logic is_aligned(input logic            is_write,
                                      input logic [BE_W-1:0] wenable,
                                      input logic [1:0]      addr_lo);
    logic ok;
    ok = 1'b0;
    if (!is_write) begin
      ok = (addr_lo == 2'b00);
    end else begin
      case (wenable)
        4'b1111:                            ok = (addr_lo == 2'b00);
        4'b0011, 4'b1100:                   ok = !addr_lo[0];
        4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
        default:                            ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Bundle of pipeline-request, memory-bus and response signals.
//   slave  : seen by the controller (takes requests, drives memory + response)
//   master : seen by the environment (pipeline stage + data memory)
interface dmem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);

  logic                                          reqValid;
  logic                                          reqWrite;
  logic [ADDR_W-1:0]                             reqAddr;
  logic [dmem_access_ctrl_pkg::BE_W-1:0]         reqWEnable;
  dmem_access_ctrl_pkg::basic_data_t             reqWData;
  logic                                          flush;

  logic                                          memReq;
  logic [ADDR_W-1:0]                             memAddr;
  logic [dmem_access_ctrl_pkg::BE_W-1:0]         memWEnable;
  dmem_access_ctrl_pkg::basic_data_t             memWData;
  logic                                          memAck;
  dmem_access_ctrl_pkg::basic_data_t             memRData;

  logic                                          stall;
  logic                                          respValid;
  dmem_access_ctrl_pkg::basic_data_t             respData;
  logic                                          fault;

  modport slave (
    input  reqValid, reqWrite, reqAddr, reqWEnable, reqWData, flush,
    input  memAck, memRData,
    output memReq, memAddr, memWEnable, memWData,
    output stall, respValid, respData, fault
  );

  modport master (
    output reqValid, reqWrite, reqAddr, reqWEnable, reqWData, flush,
    output memAck, memRData,
    input  memReq, memAddr, memWEnable, memWData,
    input  stall, respValid, respData, fault
  );

endinterface

// File: rtl/dmem_access_ctrl_align.sv
// Combinational alignment decode for an incoming request.
//   is_write/wenable/addr_lo : request kind, byte enables, low address bits
//   aligned                  : 1 when the request can be issued unchanged
module dmem_access_ctrl_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic            is_write,
  input  logic [BE_W-1:0] wenable,
  input  logic [1:0]      addr_lo,
  output logic            aligned
);

  assign aligned = is_aligned(is_write, wenable, addr_lo);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: accepts one load/store from the memory-access
// stage, issues it to data memory, waits for ack (with timeout) and returns the
// result to write-back.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request / memory / response signals (slave modport)
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  dmem_access_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  dmem_ctrl_state_e  state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   we_q, we_d;
  basic_data_t       wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              cancel_q, cancel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  basic_data_t       resp_data_q, resp_data_d;
  logic              fault_q, fault_d;

  logic aligned_c;
  logic accept_c;

  dmem_access_ctrl_align u_align (
    .is_write (bus.reqWrite),
    .wenable  (bus.reqWEnable),
    .addr_lo  (bus.reqAddr[1:0]),
    .aligned  (aligned_c)
  );

  assign accept_c = (state_q == S_IDLE) && bus.reqValid && !bus.flush && aligned_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      cancel_q    <= 1'b0;
      cnt_q       <= '0;
      resp_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      cancel_q    <= cancel_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      fault_q     <= fault_d;
    end
  end

  // Next state and next datapath values
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    cancel_d    = cancel_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    fault_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d  = S_ISSUE;
          addr_d   = bus.reqAddr;
          we_d     = bus.reqWrite ? bus.reqWEnable : '0;
          wdata_d  = bus.reqWrite ? bus.reqWData : '0;
          write_d  = bus.reqWrite;
          cancel_d = 1'b0;
        end else if (bus.reqValid && !bus.flush && !aligned_c) begin
          fault_d = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
        // A flushed store has already committed, so only loads get cancelled.
        if (bus.flush && !write_q) cancel_d = 1'b1;
      end
      S_WAIT: begin
        if (bus.flush && !write_q) cancel_d = 1'b1;
        if (bus.memAck) begin
          state_d     = S_DONE;
          resp_data_d = write_q ? '0 : bus.memRData;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d = S_IDLE;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs; stall must rise in the accepting cycle so the stage freezes at once.
  always_comb begin
    bus.memReq    = (state_q == S_ISSUE);
    bus.stall     = (state_q == S_ISSUE) || (state_q == S_WAIT) || accept_c;
    bus.respValid = (state_q == S_DONE) && !cancel_q;
  end

  assign bus.memAddr    = addr_q;
  assign bus.memWEnable = we_q;
  assign bus.memWData   = wdata_q;
  assign bus.respData   = resp_data_q;
  assign bus.fault      = fault_q;

endmodule
